// File: rtl/pronoc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pronoc_pkg: router port indices, preselect FSM states, quadrant port map   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pronoc_pkg;

  localparam logic [2:0] LOCAL = 3'd0;
  localparam logic [2:0] EAST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] WEST  = 3'd3;
  localparam logic [2:0] SOUTH = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_PEND  = 2'd2
  } presel_st_t;

  typedef struct packed {
    logic [2:0] x_port;
    logic [2:0] y_port;
  } presel_ports_t;

  // Quadrant q = {x,y}: X port is E when x=1 else W, Y port is N when y=1 else S.
  function automatic presel_ports_t presel_q_ports(input logic [1:0] q);
    presel_ports_t p;
    p.x_port = q[1] ? EAST  : WEST;
    p.y_port = q[0] ? NORTH : SOUTH;
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fmesh_presel_score.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fmesh_presel_score: signed saturating up/down score with clear and freeze  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fmesh_presel_score #(
  parameter int CNTw = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_inc,
  input  logic                   i_dec,
  input  logic                   i_clr,
  input  logic                   i_frz,
  output logic signed [CNTw-1:0] o_next
);

  localparam logic signed [CNTw-1:0] c_MAX = {1'b0, {(CNTw-1){1'b1}}};
  localparam logic signed [CNTw-1:0] c_MIN = {1'b1, {(CNTw-1){1'b0}}};

  logic signed [CNTw-1:0] r_score;
  logic signed [CNTw-1:0] w_next;

  // o_next is the score including this cycle's sample, so the threshold
  // compare upstream can act on it in the same cycle.
  always_comb begin
    w_next = r_score;
    if (!i_frz) begin
      if (i_inc && !i_dec && (r_score != c_MAX)) begin
        w_next = r_score + CNTw'(1);
      end else if (i_dec && !i_inc && (r_score != c_MIN)) begin
        w_next = r_score - CNTw'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score <= '0;
    end else if (i_clr) begin
      r_score <= '0;
    end else begin
      r_score <= w_next;
    end
  end

  assign o_next = w_next;

endmodule
`default_nettype wire

// File: rtl/fmesh_presel_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fmesh_presel_ctrl: windowed X/Y port-preference controller per quadrant    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fmesh_presel_ctrl
  import pronoc_pkg::*;
#(
  parameter string            ROUTE_TYPE  = "FULL_ADAPTIVE",
  parameter int               PPSw        = 4,
  parameter int               WINDOW      = 64,
  parameter int               CNTw        = 6,
  parameter int               THRESH      = 8,
  parameter logic [PPSw-1:0]  PRESEL_INIT = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [3:0]      congest_in,
  input  logic            hold,
  output logic [PPSw-1:0] port_pre_sel,
  output logic            update_o
);

  localparam int                     c_WW    = $clog2(WINDOW);
  localparam logic [c_WW-1:0]        c_WLAST = c_WW'(WINDOW - 1);
  localparam bit                     c_DET   = (ROUTE_TYPE == "DETERMINISTIC");
  localparam logic signed [CNTw-1:0] c_THR   = CNTw'(THRESH);
  localparam logic signed [CNTw-1:0] c_NTHR  = -c_THR;

  presel_st_t             r_st;
  presel_st_t             w_st_nxt;
  logic [c_WW-1:0]        r_win;
  logic [c_WW-1:0]        w_win_nxt;
  logic [PPSw-1:0]        r_presel;
  logic [PPSw-1:0]        w_presel_nxt;
  logic                   r_upd;
  logic                   w_upd;
  logic                   w_clr;
  logic                   w_frz;
  logic signed [CNTw-1:0] w_score [PPSw];

  always_comb begin
    w_st_nxt  = r_st;
    w_win_nxt = r_win;
    w_upd     = 1'b0;
    case (r_st)
      ST_IDLE: begin
        w_win_nxt = '0;
        if (en && !c_DET) begin
          w_st_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (!en) begin
          w_st_nxt  = ST_IDLE;
          w_win_nxt = '0;
        end else if (r_win == c_WLAST) begin
          if (hold) begin
            w_st_nxt = ST_PEND;
          end else begin
            w_upd     = 1'b1;
            w_win_nxt = '0;
          end
        end else begin
          w_win_nxt = r_win + c_WW'(1);
        end
      end
      ST_PEND: begin
        if (!en) begin
          w_st_nxt  = ST_IDLE;
          w_win_nxt = '0;
        end else if (!hold) begin
          w_st_nxt  = ST_ACCUM;
          w_upd     = 1'b1;
          w_win_nxt = '0;
        end
      end
      default: begin
        w_st_nxt  = ST_IDLE;
        w_win_nxt = '0;
      end
    endcase
  end

  // Scores accumulate only in ACCUM; they are wiped on every exit to IDLE and after an update.
  assign w_frz = (r_st != ST_ACCUM);
  assign w_clr = (r_st == ST_IDLE) || !en || w_upd;

  for (genvar q = 0; q < PPSw; q++) begin : g_quad
    localparam presel_ports_t c_P  = presel_q_ports(2'(q));
    localparam int            c_XB = int'(c_P.x_port) - 1;
    localparam int            c_YB = int'(c_P.y_port) - 1;

    logic w_xc;
    logic w_yc;

    assign w_xc = congest_in[c_XB];
    assign w_yc = congest_in[c_YB];

    fmesh_presel_score #(
      .CNTw (CNTw)
    ) u_score (
      .clk    (clk),
      .rst    (reset),
      .i_inc  (w_xc && !w_yc),
      .i_dec  (w_yc && !w_xc),
      .i_clr  (w_clr),
      .i_frz  (w_frz),
      .o_next (w_score[q])
    );

    assign w_presel_nxt[q] = (w_score[q] >= c_THR)  ? 1'b1 :
                             (w_score[q] <= c_NTHR) ? 1'b0 : r_presel[q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st     <= ST_IDLE;
      r_win    <= '0;
      r_upd    <= 1'b0;
      r_presel <= PRESEL_INIT;
    end else begin
      r_st  <= w_st_nxt;
      r_win <= w_win_nxt;
      r_upd <= w_upd;
      if (w_upd) begin
        r_presel <= w_presel_nxt;
      end
    end
  end

  assign port_pre_sel = r_presel;
  assign update_o     = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_fmesh_presel_ctrl.sv
`default_nettype none
// Bench: three controller variants (adaptive W16/T4, saturating CNTw4/T7, deterministic)
// driven in lockstep and compared each cycle against a sample-count reference model.
module tb_fmesh_presel_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       hold;
  logic [3:0] congest_in;
  logic [3:0] sel0, sel1, sel2;
  logic       upd0, upd1, upd2;
  logic [14:0] got;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fmesh_presel_ctrl #(.ROUTE_TYPE("FULL_ADAPTIVE"), .PPSw(4), .WINDOW(16), .CNTw(6),
                      .THRESH(4), .PRESEL_INIT(4'b0000)) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .congest_in(congest_in), .hold(hold),
    .port_pre_sel(sel0), .update_o(upd0));

  fmesh_presel_ctrl #(.ROUTE_TYPE("FULL_ADAPTIVE"), .PPSw(4), .WINDOW(16), .CNTw(4),
                      .THRESH(7), .PRESEL_INIT(4'b0000)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .congest_in(congest_in), .hold(hold),
    .port_pre_sel(sel1), .update_o(upd1));

  fmesh_presel_ctrl #(.ROUTE_TYPE("DETERMINISTIC"), .PPSw(4), .WINDOW(16), .CNTw(6),
                      .THRESH(4), .PRESEL_INIT(4'b0000)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .congest_in(congest_in), .hold(hold),
    .port_pre_sel(sel2), .update_o(upd2));

  assign got = {sel0, upd0, sel1, upd1, sel2, upd2};

  // Reference model: per instance, samples taken so far, whether running, whether
  // waiting for hold to drop, and plain integer scores clamped to the signed range.
  localparam int M_WIN = 16;
  int   m_lo  [3] = '{-32, -8, -32};
  int   m_hi  [3] = '{ 31,  7,  31};
  int   m_th  [3] = '{  4,  7,   4};
  bit   m_det [3] = '{1'b0, 1'b0, 1'b1};
  int   m_sc  [3][4];
  int   m_n   [3];
  bit   m_run [3];
  bit   m_wait[3];
  logic [3:0] m_sel [3];
  logic       m_upd [3];

  function automatic logic [14:0] exp_vec();
    return {m_sel[0], m_upd[0], m_sel[1], m_upd[1], m_sel[2], m_upd[2]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sel[i] = 4'b0000; m_upd[i] = 1'b0; m_n[i] = 0;
      m_run[i] = 1'b0; m_wait[i] = 1'b0;
      for (int q = 0; q < 4; q++) m_sc[i][q] = 0;
    end
  endtask

  task automatic model_apply(input int i);
    for (int q = 0; q < 4; q++) begin
      if (m_sc[i][q] >= m_th[i]) m_sel[i][q] = 1'b1;
      else if (m_sc[i][q] <= -m_th[i]) m_sel[i][q] = 1'b0;
      m_sc[i][q] = 0;
    end
    m_n[i] = 0; m_wait[i] = 1'b0; m_upd[i] = 1'b1;
  endtask

  task automatic model_step();
    bit xc, yc;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      m_upd[i] = 1'b0;
      if (m_det[i]) continue;
      if (!m_run[i]) begin
        if (en) begin m_run[i] = 1'b1; m_n[i] = 0; end
      end else if (!en) begin
        m_run[i] = 1'b0; m_wait[i] = 1'b0; m_n[i] = 0;
        for (int q = 0; q < 4; q++) m_sc[i][q] = 0;
      end else if (m_wait[i]) begin
        if (!hold) model_apply(i);
      end else begin
        for (int q = 0; q < 4; q++) begin
          xc = (q >= 2)    ? congest_in[0] : congest_in[2];
          yc = (q % 2 == 1) ? congest_in[1] : congest_in[3];
          if (xc && !yc)      m_sc[i][q] = (m_sc[i][q] + 1 > m_hi[i]) ? m_hi[i] : m_sc[i][q] + 1;
          else if (!xc && yc) m_sc[i][q] = (m_sc[i][q] - 1 < m_lo[i]) ? m_lo[i] : m_sc[i][q] - 1;
        end
        m_n[i]++;
        if (m_n[i] == M_WIN) begin
          if (hold) m_wait[i] = 1'b1;
          else model_apply(i);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; hold = 1'b0; congest_in = 4'b0000;
    model_reset();
    #2;
    total++;
    if (got !== exp_vec()) begin
      bad++; $display("FAIL reset_init got=%h exp=%h", got, exp_vec());
    end
    repeat (3) tick();
    @(negedge clk); reset = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 25; c++) begin
      congest_in = 4'($urandom);
      tick();
      total++;
      if (got !== exp_vec()) begin
        bad++; $display("FAIL reset_run c=%0d got=%h exp=%h", c, got, exp_vec());
      end
    end
    // Asynchronous assertion between edges must clear outputs at once.
    @(negedge clk); reset = 1'b1; #1;
    model_reset();
    total++;
    if (got !== 15'd0) begin
      bad++; $display("FAIL reset_async got=%h exp=%h", got, 15'd0);
    end
    repeat (2) tick();
    @(negedge clk); reset = 1'b0; en = 1'b0;
  endtask

  task automatic test_east();
    congest_in = 4'b0001; en = 1'b0;
    tick();
    en = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      total++;
      if (got !== exp_vec()) begin
        bad++; $display("FAIL east c=%0d got=%h exp=%h", c, got, exp_vec());
      end
      if (c < 17) begin
        total++;
        if (upd0 !== 1'b0) begin
          bad++; $display("FAIL east_early c=%0d upd=%b exp=0", c, upd0);
        end
      end
    end
    total++;
    if ({sel0, upd0} !== {4'b1100, 1'b1}) begin
      bad++; $display("FAIL east_result got=%b/%b exp=1100/1", sel0, upd0);
    end
  endtask

  task automatic test_north();
    congest_in = 4'b0010;
    for (int c = 1; c <= 16; c++) begin
      tick();
      total++;
      if (got !== exp_vec()) begin
        bad++; $display("FAIL north c=%0d got=%h exp=%h", c, got, exp_vec());
      end
    end
    // N congested drives every y=1 quadrant to X; bit 3 clears, bit 2 stays.
    total++;
    if ({sel0, upd0} !== {4'b0100, 1'b1}) begin
      bad++; $display("FAIL north_result got=%b/%b exp=0100/1", sel0, upd0);
    end
  endtask

  task automatic test_hysteresis();
    int hits[3];
    en = 1'b0; congest_in = 4'b0000;
    tick();
    en = 1'b1;
    tick();
    hits[0] = $urandom_range(0, 4);
    hits[1] = $urandom_range(5, 10);
    hits[2] = $urandom_range(11, 15);
    for (int c = 0; c < 16; c++) begin
      congest_in = (c == hits[0] || c == hits[1] || c == hits[2]) ? 4'b0001 : 4'b0000;
      tick();
      total++;
      if (got !== exp_vec()) begin
        bad++; $display("FAIL hyst c=%0d got=%h exp=%h", c, got, exp_vec());
      end
    end
    total++;
    if ({sel0, upd0} !== {4'b0100, 1'b1}) begin
      bad++; $display("FAIL hyst_result got=%b/%b exp=0100/1", sel0, upd0);
    end
  endtask

  task automatic test_hold();
    int pulses = 0;
    congest_in = 4'b0001;
    for (int c = 1; c <= 21; c++) begin
      hold = (c >= 15 && c <= 20);
      tick();
      pulses += int'(upd0);
      total++;
      if (got !== exp_vec()) begin
        bad++; $display("FAIL hold c=%0d got=%h exp=%h", c, got, exp_vec());
      end
    end
    hold = 1'b0;
    total++;
    if ({sel0, upd0, pulses} !== {4'b1100, 1'b1, 32'd1}) begin
      bad++; $display("FAIL hold_result got=%b/%b/%0d exp=1100/1/1", sel0, upd0, pulses);
    end
  endtask

  task automatic test_random();
    logic [3:0] mask = 4'b1111;
    int det_upd = 0;
    for (int c = 0; c < 800; c++) begin
      if (c % 32 == 0) mask = 4'($urandom);
      congest_in = 4'($urandom) & mask;
      hold = ($urandom_range(0, 9) < 2);
      en = ($urandom_range(0, 99) >= 2);
      tick();
      det_upd += int'(upd2);
      total++;
      if (got !== exp_vec()) begin
        bad++; $display("FAIL random c=%0d got=%h exp=%h", c, got, exp_vec());
      end
    end
    total++;
    if ({sel2, det_upd} !== {4'b0000, 32'd0}) begin
      bad++; $display("FAIL deterministic got=%b/%0d exp=0000/0", sel2, det_upd);
    end
  endtask

  initial begin
    test_reset();
    test_east();
    test_north();
    test_hysteresis();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
